score_display_ctrl: RTL and testbench
=====================================

# score_display_ctrl

Parametrised score keeper and multiplexed seven-segment driver for the ping-pong game. It holds one saturating BCD score per player and accepts single-cycle point pulses from the game FSM. It detects the winning score and freezes play, and it time-multiplexes all score digits onto one shared segment bus with per-digit enables. It sits between the game logic and the board display pins, and supersedes the static per-player decoder.

## Interface
Parameters:
- `N_PLAYERS`, 2: number of players/score channels (1..4).
- `DIGITS`, 2: BCD digits per player (1..3).
- `WIN_SCORE`, 11: score that ends the game; must be ≤ 10^DIGITS−1.
- `SCAN_DIV`, 50000: clk cycles per digit slot (≥2).
- `BLANK_LZ`, 1: 1 blanks leading zeros (digit 0 of each player is never blanked).

Ports:
- `clk` in 1: system clock, single domain.
- `reset` in 1: asynchronous, active-low reset.
- `point` in N_PLAYERS: one-cycle pulse per player; bit p awards one point to player p.
- `clear` in 1: synchronous, active-high new-game request.
- `seg` out 7: shared segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- `an` out N_PLAYERS*DIGITS: digit enables, active-low, exactly one low at a time.
- `winner` out N_PLAYERS: bit p high once player p reached WIN_SCORE.
- `game_over` out 1: high while any winner bit is set.

## Operation
- Scores are stored as DIGITS BCD nibbles per player and reset to 0.
- Point handling:
  - `point[p]` high while `game_over`=0 increments player p's score by 1 with BCD carry (9→0, carry up).
  - A score at 10^DIGITS−1 saturates and does not wrap.
- Simultaneous points in one cycle all count.
- Win detection:
  - When an updated score equals WIN_SCORE, `winner[p]` sets.
  - If several players reach WIN_SCORE in the same cycle, all their bits set (tie).
- While `game_over`=1, `point` is ignored and scores hold.
- `clear`=1 zeroes all scores, `winner` and `game_over` on the next edge. `clear` has priority over a same-cycle `point`. The scan counter is unaffected.
- Display slot k = p*DIGITS + d, where d=0 is the least significant digit of player p. Slot k drives `an[k]` low.
- Scan sequence:
  - A divider counts 0..SCAN_DIV−1.
  - On terminal count, the slot index advances k→k+1, wrapping from N_PLAYERS*DIGITS−1 to 0.
- Segment patterns (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. The blank pattern is 1111111.
- Leading-zero blanking: with BLANK_LZ=1, digit d>0 is blanked when it and all higher digits of that player are 0.
- While `game_over`=1, the winner's digits blink. They are blanked during every other full scan cycle, toggled at each wrap to slot 0. Non-winners stay lit.

## Timing
- Reset values:
  - `seg`=1000000, `an` = all ones except `an[0]`=0.
  - `winner`=0, `game_over`=0.
  - Scores, divider, slot index and blink phase = 0.
- Score update: the registered score changes on the edge sampling `point`.
- `winner` and `game_over` are registered on the same edge as the winning increment, so latency is 1 cycle.
- `seg` and `an` are registered. They change together one cycle after the slot index advances, so no two enables are ever low at once and there is no cross-digit ghosting.
- A new score is visible on its digit within one full scan (≤ N_PLAYERS*DIGITS*SCAN_DIV + 2 cycles).
- Reset asserted mid-operation forces all reset values immediately and asynchronously. Release is on the next clk edge after `reset` rises.

## Structure
- Package `score_pkg`:
  - Seven-segment digit constants SEG_0..SEG_9 and SEG_BLANK.
  - A BCD-digit type.
- Sub-module `seg7_encode`: combinational BCD+blank → 7-bit active-low pattern. It is instantiated once, on the shared bus.
- Top: the BCD counter array (generate over players/digits), the win logic, the scan divider, and the output registers.

## Test plan
- Reset with defaults, then 3 pulses on `point[0]` → after one full scan, slot 0 shows 0110000, slot 1 is blank, and slots 2/3 show 1000000/blank.
- 9 then 1 pulses on player 1 → player 1 reads "10", with slot 3 = 1111001 and slot 2 = 1000000.
- Drive player 0 to 11 → `winner`=01 and `game_over`=1 on the 11th-pulse edge. Further pulses are ignored. Player 0's digits blank on alternate scans.
- Both players at 10, pulse `point`=11 in one cycle → `winner`=11, `game_over`=1.
- `clear` and `point[1]` in the same cycle → all scores 0, `winner`=0. Also: with DIGITS=1 and WIN_SCORE=9, the score saturates at 9.
- Assert `reset` mid-scan at slot 2 → `an`=1110 and `seg`=1000000 immediately, before the next clk edge.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and active-low seven-segment patterns (gfedcba) for the
// ping-pong score display.
package score_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-low seven-segment pattern with blanking.
module seg7_encode
  import score_pkg::*;
(
  input  bcd_t       digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_ctrl.sv
// Saturating BCD score keeper with win detection and a multiplexed,
// registered seven-segment scan driver.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int unsigned N_PLAYERS = 2,
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned WIN_SCORE = 11,
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_LZ  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PLAYERS-1:0]        point,
  input  logic                        clear,
  output logic [6:0]                  seg,
  output logic [N_PLAYERS*DIGITS-1:0] an,
  output logic [N_PLAYERS-1:0]        winner,
  output logic                        game_over
);

  localparam int unsigned NSLOT  = N_PLAYERS * DIGITS;
  localparam int unsigned SLOT_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
  localparam logic [NSLOT-1:0] AN_RST = ~NSLOT'(1);

  logic [N_PLAYERS-1:0][DIGITS-1:0][3:0] score_q, score_d;
  logic [N_PLAYERS-1:0] winner_q, win_set;
  logic                 game_over_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic                 blink_q, blink_d;
  logic [6:0]           seg_q, seg_d;
  logic [NSLOT-1:0]     an_q, an_d;

  logic [NSLOT-1:0][3:0] slot_digit;
  logic [NSLOT-1:0]      lz_blank, blink_blank;
  bcd_t                  cur_digit;
  logic                  cur_blank;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    logic [DIGITS-1:0] carry, nine, win_eq;
    logic              inc;

    // A full-nines score saturates: the increment is suppressed entirely.
    assign inc      = point[p] & ~game_over_q & ~(&nine);
    assign carry[0] = inc;
    assign win_set[p] = inc & (&win_eq);

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      localparam bcd_t WIN_DIGIT = bcd_t'((WIN_SCORE / (10 ** d)) % 10);

      assign nine[d] = (score_q[p][d] == 4'd9);
      if (d + 1 < DIGITS) begin : g_carry
        assign carry[d+1] = carry[d] & nine[d];
      end
      assign score_d[p][d] = !carry[d] ? score_q[p][d]
                           : (nine[d] ? 4'd0 : score_q[p][d] + 4'd1);
      assign win_eq[d] = (score_d[p][d] == WIN_DIGIT);

      assign slot_digit[p*DIGITS+d]  = score_q[p][d];
      assign lz_blank[p*DIGITS+d]    = (BLANK_LZ != 0) && (d > 0) &&
                                       (score_q[p][DIGITS-1:d] == '0);
      assign blink_blank[p*DIGITS+d] = blink_q & game_over_q & winner_q[p];
    end
  end

  always_comb begin
    div_d   = div_q + 1'b1;
    slot_d  = slot_q;
    blink_d = blink_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      if (slot_q == SLOT_W'(NSLOT - 1)) begin
        slot_d  = '0;
        blink_d = ~blink_q;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // Outputs are built from the current slot so seg/an move together one
  // cycle after the slot index, never exposing two enables at once.
  always_comb begin
    cur_digit = '0;
    cur_blank = 1'b1;
    an_d      = '1;
    for (int unsigned k = 0; k < NSLOT; k++) begin
      if (slot_q == SLOT_W'(k)) begin
        cur_digit = slot_digit[k];
        cur_blank = lz_blank[k] | blink_blank[k];
        an_d[k]   = 1'b0;
      end
    end
  end

  seg7_encode u_seg7_encode (
    .digit_i (cur_digit),
    .blank_i (cur_blank),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_q     <= '0;
      winner_q    <= '0;
      game_over_q <= 1'b0;
      div_q       <= '0;
      slot_q      <= '0;
      blink_q     <= 1'b0;
      seg_q       <= SEG_0;
      an_q        <= AN_RST;
    end else begin
      if (clear) begin
        score_q     <= '0;
        winner_q    <= '0;
        game_over_q <= 1'b0;
      end else begin
        score_q     <= score_d;
        winner_q    <= winner_q | win_set;
        game_over_q <= game_over_q | (|win_set);
      end
      div_q   <= div_d;
      slot_q  <= slot_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign winner    = winner_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: directed table, hand-written corner sequences
// and random points, all checked every cycle against an arithmetic model.
module tb_score_display_ctrl;

  localparam int SD = 3;
  localparam int NS = 4;

  typedef struct {
    logic [1:0] pt;
    logic       clr;
    logic [1:0] win;
    logic       go;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] point;
  logic       clear;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] winner;
  logic       game_over;

  logic [0:0] point2;
  logic [6:0] seg2;
  logic [0:0] an2;
  logic [0:0] winner2;
  logic       game_over2;

  int         mscore[2];
  logic [1:0] mwin;
  int         n;
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl[$];
  logic [6:0] cap[4];

  always #5 clk = ~clk;

  score_display_ctrl #(
    .N_PLAYERS (2),
    .DIGITS    (2),
    .WIN_SCORE (11),
    .SCAN_DIV  (SD),
    .BLANK_LZ  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .point     (point),
    .clear     (clear),
    .seg       (seg),
    .an        (an),
    .winner    (winner),
    .game_over (game_over)
  );

  score_display_ctrl #(
    .N_PLAYERS (1),
    .DIGITS    (1),
    .WIN_SCORE (9),
    .SCAN_DIV  (2),
    .BLANK_LZ  (1)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .point     (point2),
    .clear     (clear),
    .seg       (seg2),
    .an        (an2),
    .winner    (winner2),
    .game_over (game_over2)
  );

  function automatic logic [6:0] digit_seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Expected pattern for slot k from the model score held before this edge.
  function automatic logic [6:0] exp_seg(input int k, input int blink);
    int p = k / 2;
    int d = k % 2;
    int v = mscore[p];
    if (d > 0 && v < 10) return 7'h7F;
    if (mwin[p] && blink != 0) return 7'h7F;
    return digit_seg((d == 0) ? (v % 10) : ((v / 10) % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [1:0] pt, input logic clr, input logic pt2);
    int slot, blink, s;
    logic [3:0] ean;
    logic [6:0] eseg;
    point  = pt;
    clear  = clr;
    point2 = pt2;
    @(posedge clk);
    n++;
    slot  = ((n - 1) / SD) % NS;
    blink = ((n - 1) / (SD * NS)) % 2;
    ean   = 4'hF;
    ean[slot] = 1'b0;
    eseg  = exp_seg(slot, blink);
    if (clr) begin
      mscore[0] = 0;
      mscore[1] = 0;
      mwin = 2'b00;
    end else if (mwin == 2'b00) begin
      for (int p = 0; p < 2; p++) begin
        if (pt[p]) begin
          s = (mscore[p] + 1 > 99) ? 99 : mscore[p] + 1;
          mscore[p] = s;
          if (s == 11) mwin[p] = 1'b1;
        end
      end
    end
    @(negedge clk);
    chk("an", an, ean);
    chk("seg", seg, eseg);
    chk("winner", winner, mwin);
    chk("game_over", game_over, |mwin);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    point  = '0;
    clear  = 1'b0;
    point2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_winner", winner, 2'b00);
    chk("rst_game_over", game_over, 1'b0);
    mscore[0] = 0;
    mscore[1] = 0;
    mwin = 2'b00;
    n = 0;
    reset = 1'b1;
  endtask

  task automatic scan_capture();
    for (int k = 0; k < 4; k++) cap[k] = 'x;
    for (int i = 0; i < NS * SD + 2; i++) begin
      step(2'b00, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) if (an[k] === 1'b0) cap[k] = seg;
    end
  endtask

  task automatic add(input int cnt, input logic [1:0] pt, input logic clr,
                     input logic [1:0] win, input logic go);
    for (int i = 0; i < cnt; i++) tbl.push_back('{pt, clr, win, go});
  endtask

  initial begin
    int saw9;
    logic [1:0] rp;
    logic       rc;

    do_reset();

    // Three points for player 0: "3", leading zero blanked, player 1 "0".
    repeat (3) step(2'b01, 1'b0, 1'b0);
    scan_capture();
    chk("p0_3_slot0", cap[0], 7'b0110000);
    chk("p0_3_slot1", cap[1], 7'b1111111);
    chk("p0_3_slot2", cap[2], 7'b1000000);
    chk("p0_3_slot3", cap[3], 7'b1111111);

    // Player 1 to 10 through a BCD carry.
    step(2'b00, 1'b1, 1'b0);
    repeat (9) step(2'b10, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0);
    scan_capture();
    chk("p1_10_slot3", cap[3], 7'b1111001);
    chk("p1_10_slot2", cap[2], 7'b1000000);

    // Directed table: win, frozen play with blinking, clear priority, tie.
    step(2'b00, 1'b1, 1'b0);
    add(10, 2'b01, 1'b0, 2'b00, 1'b0);
    add(1,  2'b01, 1'b0, 2'b01, 1'b1);
    add(1,  2'b10, 1'b0, 2'b01, 1'b1);
    add(1,  2'b11, 1'b0, 2'b01, 1'b1);
    add(26, 2'b00, 1'b0, 2'b01, 1'b1);
    add(1,  2'b10, 1'b1, 2'b00, 1'b0);
    add(10, 2'b11, 1'b0, 2'b00, 1'b0);
    add(1,  2'b11, 1'b0, 2'b11, 1'b1);
    add(1,  2'b00, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].pt, tbl[i].clr, 1'b0);
      chk("tbl_winner", winner, tbl[i].win);
      chk("tbl_game_over", game_over, tbl[i].go);
    end

    // Single-digit instance: wins at 9, further points ignored, shows 9.
    for (int i = 0; i < 12; i++) begin
      step(2'b00, 1'b0, 1'b1);
      chk("d1_winner", winner2, (i >= 8) ? 1 : 0);
    end
    saw9 = 0;
    for (int i = 0; i < 8; i++) begin
      step(2'b00, 1'b0, 1'b0);
      chk("d1_an", an2, 1'b0);
      chk("d1_seg", (seg2 == 7'b0010000 || seg2 == 7'b1111111) ? 1 : 0, 1);
      if (seg2 == 7'b0010000) saw9++;
    end
    chk("d1_seen9", (saw9 > 0) ? 1 : 0, 1);

    // Random play against the model.
    for (int i = 0; i < 400; i++) begin
      rp[0] = ($urandom_range(0, 2) == 0);
      rp[1] = ($urandom_range(0, 2) == 0);
      rc    = ($urandom_range(0, 29) == 0);
      step(rp, rc, 1'b0);
    end

    // Asynchronous reset while slot 2 is on the bus.
    step(2'b00, 1'b1, 1'b0);
    repeat (3) step(2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 20 && an !== 4'b1011; i++) step(2'b00, 1'b0, 1'b0);
    chk("async_pre_an", an, 4'b1011);
    chk("async_pre_seg", seg, 7'b0110000);
    #1 reset = 1'b0;
    #1;
    chk("async_an", an, 4'b1110);
    chk("async_seg", seg, 7'b1000000);
    chk("async_winner", winner, 2'b00);
    do_reset();
    repeat (NS * SD + 2) step(2'b00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
